// File: rtl/add16_share_pkg.sv
// Shared types and constants for the time-shared 16-bit add/subtract sequencer.
// Used by add16_share_seq and its round-robin arbiter.
package add16_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int LANE_W = 8;

    // Subtraction is A + ~B + 1, so B is inverted once at accept time.
    function automatic logic [2*LANE_W-1:0] cond_invert(
        input logic [2*LANE_W-1:0] b,
        input logic                op
    );
        return (op == OP_ADD) ? b : ~b;
    endfunction

endpackage

// File: rtl/add16_share_seq_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index and wraps.
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_gnt
);

    // Two ordered passes: indices above the pointer first, then the wrapped range.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_gnt && req[i] && (i > int'(ptr))) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_gnt && req[i] && (i <= int'(ptr))) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/add16_share_seq.sv
// Time-shares one external 8-bit adder among NREQ requesters: each 16-bit op runs as a low then high byte pass.
// Define ADD16_SHARE_FLAGS_EN to add registered rsp_zero and rsp_ovf outputs.
module add16_share_seq
    import add16_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    output logic              add_cin,
    input  logic [7:0]        add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_sum,
    output logic              rsp_cout
`ifdef ADD16_SHARE_FLAGS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_ovf
`endif
);

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       ptr;
    logic [NREQ-1:0]      gnt;
    logic [IDW-1:0]       gnt_idx;
    logic                 any_gnt;
    logic                 accept;
    logic [15:0]          sel_a;
    logic [15:0]          sel_b;
    logic                 sel_sub;
    logic [15:0]          op_a;
    logic [15:0]          op_b;
    logic                 op_sub;
    logic [IDW-1:0]       op_id;
    logic [LANE_W-1:0]    sum_lo;
    logic                 c_lo;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a   = req_a[16*i +: 16];
                sel_b   = req_b[16*i +: 16];
                sel_sub = req_sub[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The adder ports are only driven during the two byte passes; reset masks the grant.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && any_gnt) begin
                    req_ready = gnt;
                    accept    = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                add_a     = op_a[LANE_W-1:0];
                add_b     = op_b[LANE_W-1:0];
                add_cin   = (op_sub == OP_SUB);
                state_nxt = HI;
            end
            HI: begin
                add_a     = op_a[2*LANE_W-1:LANE_W];
                add_b     = op_b[2*LANE_W-1:LANE_W];
                add_cin   = c_lo;
                state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= IDW'(NREQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            op_id    <= '0;
            sum_lo   <= '0;
            c_lo     <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            if (accept) begin
                ptr    <= gnt_idx;
                op_a   <= sel_a;
                op_b   <= cond_invert(sel_b, sel_sub);
                op_sub <= sel_sub;
                op_id  <= gnt_idx;
            end
            if (state == LO) begin
                sum_lo <= add_s;
                c_lo   <= add_cout;
            end
            // Response registers only change on the HI pass, so they hold while DONE stalls.
            if (state == HI) begin
                rsp_sum  <= {add_s, sum_lo};
                rsp_cout <= add_cout;
                rsp_id   <= op_id;
            end
        end
    end

`ifdef ADD16_SHARE_FLAGS_EN
    // Carry into bit 15 is recovered from the sum bit and the two operand bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
        end else if (state == HI) begin
            rsp_zero <= ({add_s, sum_lo} == 16'h0000);
            rsp_ovf  <= op_a[15] ^ op_b[15] ^ add_s[LANE_W-1] ^ add_cout;
        end
    end
`endif

endmodule

// File: tb/tb_add16_share_seq.sv
// Scoreboard bench for add16_share_seq: requests are predicted by a round-robin/arithmetic model,
// responses are checked by an independent monitor. Honours ADD16_SHARE_FLAGS_EN.
module tb_add16_share_seq;
    import add16_share_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_sub = '0;
    logic [NREQ*16-1:0] req_a = '0;
    logic [NREQ*16-1:0] req_b = '0;
    logic [7:0]         add_a;
    logic [7:0]         add_b;
    logic               add_cin;
    logic [7:0]         add_s;
    logic               add_cout;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_sum;
    logic               rsp_cout;
`ifdef ADD16_SHARE_FLAGS_EN
    logic               rsp_zero;
    logic               rsp_ovf;
`endif

    typedef struct {
        int          id;
        logic        sub;
        logic [15:0] a;
        logic [15:0] bx;
        logic [15:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        c_lo;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   mdl_ptr   = NREQ - 1;
    bit   refill    = 1'b0;
    bit   rand_mode = 1'b0;

    add16_share_seq #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADD16_SHARE_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf)
`endif
    );

    // Stand-in for the external 8-bit adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int modelGrant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic exp_t makeExp(input int id, input logic sub, input logic [15:0] a,
                                     input logic [15:0] b, input int c);
        exp_t        e;
        int unsigned full;
        e.id      = id;
        e.sub     = sub;
        e.a       = a;
        e.bx      = sub ? ~b : b;
        e.acc_cyc = c;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            e.ovf  = (a[15] != b[15]) && (e.sum[15] != a[15]);
        end else begin
            full   = 32'(a) + 32'(b);
            e.sum  = full[15:0];
            e.cout = full[16];
            e.ovf  = (a[15] == b[15]) && (e.sum[15] != a[15]);
        end
        e.zero = (e.sum == 16'h0000);
        e.c_lo = (32'(a[7:0]) + 32'(e.bx[7:0]) + 32'(sub)) > 32'd255;
        return e;
    endfunction

    function automatic logic [15:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic applyStimulus(input int id, input logic sub, input logic [15:0] a, input logic [15:0] b);
        req_sub[id]          = sub;
        req_a[16*id +: 16]   = a;
        req_b[16*id +: 16]   = b;
        req_valid[id]        = 1'b1;
    endtask

    task automatic checkReset();
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("rst_rsp_sum", 32'(rsp_sum), 0);
        checkOutput("rst_rsp_cout", 32'(rsp_cout), 0);
        checkOutput("rst_add", 32'({add_a, add_b, add_cin}), 0);
`ifdef ADD16_SHARE_FLAGS_EN
        checkOutput("rst_flags", 32'({rsp_zero, rsp_ovf}), 0);
`endif
    endtask

    // One clock of the request side: predict/observe the grant, then update stimulus.
    task automatic step();
        int              g;
        int              pred;
        logic [NREQ-1:0] exp_vec;
        exp_t            e;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                checkOutput("ready_busy", 32'(req_ready), 0);
                if (cyc == e.acc_cyc + 1) begin
                    checkOutput("lo_add_a", 32'(add_a), 32'(e.a[7:0]));
                    checkOutput("lo_add_b", 32'(add_b), 32'(e.bx[7:0]));
                    checkOutput("lo_add_cin", 32'(add_cin), 32'(e.sub));
                end else if (cyc == e.acc_cyc + 2) begin
                    checkOutput("hi_add_a", 32'(add_a), 32'(e.a[15:8]));
                    checkOutput("hi_add_b", 32'(add_b), 32'(e.bx[15:8]));
                    checkOutput("hi_add_cin", 32'(add_cin), 32'(e.c_lo));
                end
            end else begin
                pred    = modelGrant(req_valid, mdl_ptr);
                exp_vec = '0;
                if (pred >= 0) exp_vec[pred] = 1'b1;
                checkOutput("req_ready", 32'(req_ready), 32'(exp_vec));
                checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
                checkOutput("idle_add", 32'({add_a, add_b, add_cin}), 0);
                if (pred >= 0 && req_ready == exp_vec) begin
                    exp_q.push_back(makeExp(pred, req_sub[pred], req_a[16*pred +: 16],
                                            req_b[16*pred +: 16], cyc));
                    mdl_ptr = pred;
                    grant_log.push_back(pred);
                    g = pred;
                end
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            req_valid[g] = 1'b0;
            if (refill) applyStimulus(g, 1'($urandom_range(0, 1)), randOperand(), randOperand());
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    applyStimulus(i, 1'($urandom_range(0, 1)), randOperand(), randOperand());
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid != '0) && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput("drain_pending", 32'({req_valid, 8'(exp_q.size())}), 0);
    endtask

    // Response monitor: sampled 1 time unit after the falling edge.
    logic [15:0]    h_sum;
    logic [IDW-1:0] h_id;
    logic           h_cout;
    logic [1:0]     h_flags;
    logic [1:0]     cur_flags;
    bit             prev_stall = 1'b0;
    bit             was_valid  = 1'b0;
    int             valid_since = 0;
    exp_t           mon_e;

    always @(negedge clk) begin
        #1;
`ifdef ADD16_SHARE_FLAGS_EN
        cur_flags = {rsp_zero, rsp_ovf};
`else
        cur_flags = 2'b00;
`endif
        if (rst) begin
            prev_stall = 1'b0;
            was_valid  = 1'b0;
        end else begin
            if (rsp_valid && !was_valid) valid_since = cyc;
            if (prev_stall && rsp_valid) begin
                checkOutput("stall_sum", 32'(rsp_sum), 32'(h_sum));
                checkOutput("stall_id", 32'(rsp_id), 32'(h_id));
                checkOutput("stall_cout_flags", 32'({rsp_cout, cur_flags}), 32'({h_cout, h_flags}));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                    checkOutput("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                    checkOutput("rsp_cout", 32'(rsp_cout), 32'(mon_e.cout));
                    checkOutput("latency", 32'(valid_since - mon_e.acc_cyc), 3);
`ifdef ADD16_SHARE_FLAGS_EN
                    checkOutput("rsp_flags", 32'(cur_flags), 32'({mon_e.zero, mon_e.ovf}));
`endif
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            was_valid  = rsp_valid;
            h_sum      = rsp_sum;
            h_id       = rsp_id;
            h_cout     = rsp_cout;
            h_flags    = cur_flags;
        end
    end

    int exp_ids[5] = '{0, 1, 2, 3, 0};

    initial begin
        $display("[TB] start");
        req_valid = 4'b0010;
        #1;
        checkReset();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(0, OP_ADD, 16'h00FF, 16'h0001);
        drain(40);
        applyStimulus(1, OP_SUB, 16'h1234, 16'h1235);
        drain(40);
        applyStimulus(1, OP_SUB, 16'h1235, 16'h1234);
        drain(40);
        applyStimulus(3, OP_ADD, 16'hFFFF, 16'h0001);
        drain(40);
        applyStimulus(3, OP_ADD, 16'h7FFF, 16'h0001);
        drain(40);

        $display("[TB] round-robin with all requesters held");
        grant_log.delete();
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'($urandom_range(0, 1)), randOperand(), randOperand());
        for (int n = 0; n < 100 && grant_log.size() < 5; n++) step();
        refill = 1'b0;
        drain(100);
        for (int i = 0; i < 5; i++) begin
            checkOutput("rr_order", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_ids[i]));
        end

        $display("[TB] response stall");
        rsp_ready = 1'b0;
        applyStimulus(3, OP_ADD, 16'h9000, 16'h8000);
        for (int n = 0; n < 8; n++) step();
        checkOutput("stall_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        drain(20);

        $display("[TB] reset during HI pass");
        applyStimulus(2, OP_ADD, 16'h0101, 16'h0202);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checkReset();
        exp_q.delete();
        mdl_ptr   = NREQ - 1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) step();
        grant_log.delete();
        applyStimulus(2, OP_SUB, 16'h0005, 16'h0007);
        applyStimulus(0, OP_ADD, 16'h0F0F, 16'hF0F1);
        drain(40);
        checkOutput("post_reset_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 0);

        $display("[TB] randomized traffic");
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) step();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        drain(200);
        checkOutput("leftover", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
